// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci PRBS generator and checker.
// The generator and the checker both use the feedback function below.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned TAP_A  = 15;
    localparam int unsigned TAP_B  = 13;
    localparam int unsigned TAP_C  = 12;
    localparam int unsigned TAP_D  = 10;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } lfsr_chk_state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to the serial stream, then flywheels
// while locked, counting bit errors and dropping lock on an error burst.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_COUNT    = 32,
    parameter int unsigned WINDOW        = 64,
    parameter int unsigned UNLOCK_ERRORS = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             clear_cnt_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] bit_count_o
);

    localparam int unsigned FillW = $clog2(LFSR_W);
    localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WinW  = $clog2(WINDOW);
    localparam int unsigned WerrW = $clog2(UNLOCK_ERRORS + 1);

    lfsr_chk_state_t   state_q, state_d;
    logic [LFSR_W-1:0] hist_q, hist_d;
    logic [FillW-1:0]  fill_q, fill_d;
    logic [GoodW-1:0]  good_q, good_d;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic [WerrW-1:0]  win_err_q, win_err_d;
    logic              err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;

    logic              pred;
    logic              mismatch;
    logic [WerrW-1:0]  win_err_inc;

    assign pred        = lfsr_fb(hist_q);
    assign mismatch    = in_bit_i != pred;
    assign win_err_inc = win_err_q + WerrW'(mismatch);

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;

        if (in_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    hist_d = {hist_q[LFSR_W-2:0], in_bit_i};
                    fill_d = fill_q + FillW'(1);
                    if (fill_q == FillW'(LFSR_W - 1)) begin
                        state_d = SYNC;
                        fill_d  = '0;
                    end
                end
                SYNC: begin
                    hist_d = {hist_q[LFSR_W-2:0], in_bit_i};
                    // An all-zero history is the LFSR lockup state and predicts nothing.
                    if (!mismatch && hist_q != '0) begin
                        good_d = good_q + GoodW'(1);
                    end else begin
                        good_d = '0;
                    end
                    if (good_d == GoodW'(LOCK_COUNT)) begin
                        state_d   = LOCKED;
                        good_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the local LFSR runs on its own prediction, so a
                    // corrupted input bit does not propagate into later checks.
                    hist_d      = {hist_q[LFSR_W-2:0], pred};
                    err_pulse_d = mismatch;
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                    if (mismatch && err_count_q != '1) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    if (win_err_inc == WerrW'(UNLOCK_ERRORS)) begin
                        state_d   = HUNT;
                        fill_d    = '0;
                        good_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WinW'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WinW'(1);
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clear_cnt_i) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q     <= HUNT;
            hist_q      <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked_o    = (state_q == LOCKED);
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_count_q;
    assign bit_count_o = bit_count_q;

endmodule
